// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter feeding a single UART transmitter: start bit, 8 data bits MSB first, stop bit.
// Each serial bit is held for CLKS_PER_BIT clocks; the line idles high.
module uart_tx_scheduler #(
    parameter int N_REQ        = 4,
    parameter int CLKS_PER_BIT = 16,
    localparam int SRC_W       = $clog2(N_REQ)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [N_REQ-1:0]     req_i,
    input  logic [8*N_REQ-1:0]   data_i,
    output logic [N_REQ-1:0]     grant_o,
    output logic                 busy_o,
    output logic [SRC_W-1:0]     src_id_o,
    output logic                 frame_done_o,
    output logic                 tx_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t             state_q;
    logic [SRC_W-1:0]   ptr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2:0]         idx_q;
    logic [7:0]         byte_q;
    logic [N_REQ-1:0]   grant_q;
    logic               busy_q;
    logic [SRC_W-1:0]   src_q;
    logic               done_q;
    logic               tx_q;

    logic               win_vld;
    logic [SRC_W-1:0]   win_idx;
    logic [SRC_W-1:0]   ptr_d;

    // Scan from ptr_q downwards in priority so the lowest offset from the pointer wins last.
    always_comb begin
        int j;
        win_vld = 1'b0;
        win_idx = '0;
        j       = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = int'(ptr_q) + k;
            if (j >= N_REQ) j = j - N_REQ;
            if (req_i[SRC_W'(j)]) begin
                win_vld = 1'b1;
                win_idx = SRC_W'(j);
            end
        end
        ptr_d = (int'(win_idx) == N_REQ - 1) ? '0 : win_idx + SRC_W'(1);
    end

    // Payload register carries no reset; it is only consumed after a fresh capture.
    always_ff @(posedge clk_i) begin
        if (state_q == IDLE && win_vld) begin
            byte_q <= data_i[{win_idx, 3'b000} +: 8];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            grant_q <= '0;
            busy_q  <= 1'b0;
            src_q   <= '0;
            done_q  <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            grant_q <= '0;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                    cnt_q  <= '0;
                    if (win_vld) begin
                        grant_q[win_idx] <= 1'b1;
                        src_q   <= win_idx;
                        ptr_q   <= ptr_d;
                        state_q <= START;
                        busy_q  <= 1'b1;
                        tx_q    <= 1'b0;
                    end
                end
                START: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        idx_q   <= 3'd7;
                        tx_q    <= byte_q[7];
                        state_q <= DATA;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q <= '0;
                        if (idx_q == 3'd0) begin
                            tx_q    <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            idx_q <= idx_q - 3'd1;
                            tx_q  <= byte_q[idx_q - 3'd1];
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant_o      = grant_q;
    assign busy_o       = busy_q;
    assign src_id_o     = src_q;
    assign frame_done_o = done_q;
    assign tx_o         = tx_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: stimulus queues expected grants/bytes,
// a monitor replays each frame bit by bit against the serial line.
module tb_uart_tx_scheduler;

    localparam int NR  = 4;
    localparam int CPB = 4;

    logic          clk_i;
    logic          rst_i;
    logic [NR-1:0] req_i;
    logic [31:0]   data_i;
    logic [NR-1:0] grant_o;
    logic          busy_o;
    logic [1:0]    src_id_o;
    logic          frame_done_o;
    logic          tx_o;

    uart_tx_scheduler #(.N_REQ(NR), .CLKS_PER_BIT(CPB)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .data_i(data_i),
        .grant_o(grant_o), .busy_o(busy_o), .src_id_o(src_id_o),
        .frame_done_o(frame_done_o), .tx_o(tx_o)
    );

    typedef struct {
        logic [1:0] src;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, required %0h", name, $time, act, req);
        end
    endtask

    task automatic push(input logic [1:0] src, input logic [7:0] d);
        exp_t e;
        e.src  = src;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic wait_grant(input int idx, output int at);
        at = -1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk_i);
            if (grant_o[2'(idx)]) begin
                at = cyc;
                return;
            end
        end
        n_cmp++;
        n_bad++;
        $display("FAIL grant_wait at %0t: no grant to %0d within 200 cycles", $time, idx);
    endtask

    // Monitor: one sample per cycle on the falling edge.
    initial begin
        int         pos;
        int         k;
        logic       in_frame;
        logic       done_next;
        logic [1:0] last_src;
        logic [7:0] cur_byte;
        logic       exp_tx;
        exp_t       e;
        pos = 0; in_frame = 1'b0; done_next = 1'b0; last_src = '0; cur_byte = '0;
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                in_frame  = 1'b0;
                done_next = 1'b0;
                last_src  = '0;
            end else begin
                if (!in_frame && grant_o != '0) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_grant", 32'(grant_o), 32'(0));
                    end else begin
                        e = exp_q.pop_front();
                        chk("grant", 32'(grant_o), 32'(4'b0001 << e.src));
                        chk("src_id_at_grant", 32'(src_id_o), 32'(e.src));
                        cur_byte  = e.data;
                        last_src  = e.src;
                        in_frame  = 1'b1;
                        pos       = 0;
                        done_next = 1'b0;
                    end
                end else if (!in_frame) begin
                    chk("idle_tx_busy_done", 32'({tx_o, busy_o, frame_done_o}),
                        32'({1'b1, 1'b0, done_next}));
                    chk("src_id_hold", 32'(src_id_o), 32'(last_src));
                    done_next = 1'b0;
                end
                if (in_frame) begin
                    k = pos / CPB;
                    if (k == 0)      exp_tx = 1'b0;
                    else if (k == 9) exp_tx = 1'b1;
                    else             exp_tx = cur_byte[3'(8 - k)];
                    chk("frame_tx", 32'(tx_o), 32'(exp_tx));
                    chk("frame_busy_done", 32'({busy_o, frame_done_o}), 32'(2'b10));
                    if (pos > 0) chk("grant_clear", 32'(grant_o), 32'(0));
                    pos++;
                    if (pos == 10 * CPB) begin
                        in_frame  = 1'b0;
                        done_next = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        int t0, t1;
        rst_i  = 1'b1;
        req_i  = '0;
        data_i = '0;
        repeat (3) @(negedge clk_i);
        chk("rst_tx", 32'(tx_o), 32'(1));
        chk("rst_busy", 32'(busy_o), 32'(0));
        chk("rst_grant", 32'(grant_o), 32'(0));
        chk("rst_done", 32'(frame_done_o), 32'(0));
        chk("rst_src", 32'(src_id_o), 32'(0));
        rst_i = 1'b0;
        repeat (12) @(negedge clk_i);

        // Single frame, 8'hA5 from requester 0.
        data_i[7:0] = 8'hA5;
        push(2'd0, 8'hA5);
        req_i = 4'b0001;
        wait_grant(0, t0);
        req_i = '0;
        repeat (45) @(negedge clk_i);

        // Round-robin from a freshly reset pointer, all requesters held.
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        data_i = 32'h4332_2110;
        push(2'd0, 8'h10); push(2'd1, 8'h21); push(2'd2, 8'h32); push(2'd3, 8'h43); push(2'd0, 8'h10);
        req_i = 4'b1111;
        wait_grant(0, t0);
        for (int i = 1; i <= 4; i++) begin
            wait_grant(i % 4, t1);
            chk("rr_gap", 32'(t1 - t0), 32'(10 * CPB + 1));
            t0 = t1;
        end
        req_i = '0;
        repeat (45) @(negedge clk_i);

        // Pointer skip: after grant to 1, requesters 0 and 1 both ask; 0 wins, then held 1.
        data_i[15:8] = 8'h5C;
        push(2'd1, 8'h5C);
        req_i = 4'b0010;
        wait_grant(1, t0);
        req_i = '0;
        repeat (5) @(negedge clk_i);
        data_i[7:0]  = 8'h3E;
        data_i[15:8] = 8'h77;
        push(2'd0, 8'h3E);
        push(2'd1, 8'h77);
        req_i = 4'b0011;
        wait_grant(0, t0);
        req_i = 4'b0010;
        wait_grant(1, t1);
        chk("held_req_gap", 32'(t1 - t0), 32'(10 * CPB + 1));
        req_i = '0;
        repeat (45) @(negedge clk_i);

        // Withdrawn req[2] mid-frame, late req[3] granted right after frame_done.
        data_i[7:0] = 8'h81;
        push(2'd0, 8'h81);
        req_i = 4'b0001;
        wait_grant(0, t0);
        req_i = '0;
        repeat (10) @(negedge clk_i);
        data_i[23:16] = 8'hEE;
        req_i = 4'b0100;
        repeat (5) @(negedge clk_i);
        req_i = '0;
        repeat (5) @(negedge clk_i);
        data_i[31:24] = 8'hC3;
        push(2'd3, 8'hC3);
        req_i = 4'b1000;
        wait_grant(3, t1);
        chk("late_req_gap", 32'(t1 - t0), 32'(10 * CPB + 1));
        req_i = '0;
        repeat (45) @(negedge clk_i);

        // Reset during data bit 4 (a zero bit of 8'h4A), then a clean frame from requester 2.
        data_i[7:0] = 8'h4A;
        push(2'd0, 8'h4A);
        req_i = 4'b0001;
        wait_grant(0, t0);
        req_i = '0;
        repeat (17) @(negedge clk_i);
        #2 rst_i = 1'b1;
        #1;
        chk("async_rst_tx", 32'(tx_o), 32'(1));
        chk("async_rst_busy", 32'(busy_o), 32'(0));
        chk("async_rst_src", 32'(src_id_o), 32'(0));
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        data_i[23:16] = 8'h96;
        push(2'd2, 8'h96);
        req_i = 4'b0100;
        wait_grant(2, t0);
        req_i = '0;
        repeat (45) @(negedge clk_i);

        chk("queue_drained", 32'(exp_q.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Shares one UART serial transmit line between N_REQ byte sources using round-robin arbitration.
- Accepts a byte from the winning requester and serialises it as a framed UART character: start bit, 8 data bits MSB first, stop bit.
- Each bit is held for CLKS_PER_BIT clocks.
- Sits between on-chip byte producers and the chip-level tx pin. It is the transmit-side counterpart to the team's Receiver.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- CLKS_PER_BIT, 16, clock cycles per serial bit (>=1; 1 gives one bit per clock).

Ports:
- CLK  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- req  input  N_REQ  per-requester request; req[i] with data slice i valid.
- data  input  8*N_REQ  byte for requester i at data[8*i+7:8*i].
- grant  output  N_REQ  one-hot, one-cycle pulse: byte of that requester captured.
- busy  output  1  high while a frame is in progress (START..STOP).
- src_id  output  $clog2(N_REQ)  index of current/last granted requester.
- frame_done  output  1  one-cycle pulse at the end of the stop bit.
- tx  output  1  serial line; idles high.

Behaviour:
- Reset (async, any state, mid-frame included):
  - state=IDLE, tx=1 immediately, grant=0, busy=0, frame_done=0, src_id=0.
  - Round-robin pointer ptr=0; bit and clock counters cleared.
  - An aborted frame is dropped and never resumed.
- All outputs are registered.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - tx=1, busy=0.
  - If any req bit is set at a rising edge, the winner w is the first set bit scanning ptr, ptr+1, ... mod N_REQ.
  - On that edge: data slice w latched into shift register, grant[w]=1 for exactly one cycle, src_id=w, ptr=(w+1) mod N_REQ, state=START, busy=1, tx=0.
  - If no req is set, remain in IDLE.
- START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit index 7.
- DATA:
  - tx = byte[idx] for CLKS_PER_BIT cycles per bit; idx counts 7 down to 0 (MSB first).
  - After bit 0 completes, go to STOP.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles.
  - On the final cycle's edge: frame_done=1 for one cycle, busy=0, state=IDLE.
- Frame length: exactly 10*CLKS_PER_BIT cycles from tx falling to busy falling.
- Minimum gap between frames is 1 cycle, the IDLE arbitration cycle, with tx=1.
- Handshake:
  - A requester holds req[i] and its data stable until it sees grant[i].
  - Deasserting req before grant withdraws the request; no capture occurs.
  - req held after grant is treated as a new request. Round-robin still applies, so other pending requesters win first.
  - req changes during a frame are ignored; only the IDLE cycle samples req.
- Fairness: with all requesters continuously requesting, grants cycle 0,1,2,...,N_REQ-1,0,...
- src_id holds its value after frame_done until the next grant.
- Clock counter width is $clog2(CLKS_PER_BIT)+1 and wraps 0..CLKS_PER_BIT-1. With CLKS_PER_BIT=1, each bit lasts one cycle.

Test Plan:
- Reset sequence, no req:
  - Stimulus: CLKS_PER_BIT=4, N_REQ=4, hold Reset then release, no req.
  - Required: tx=1, busy=0, grant=0, frame_done=0, src_id=0 indefinitely.
- Single frame:
  - Stimulus: req=0001, data[7:0]=8'hA5.
  - Required: grant=0001 for 1 cycle; tx sequence (4 cycles each) 0, then 1,0,1,0,0,1,0,1, then 1.
  - Required: frame_done pulses 40 cycles after tx falls; busy high for exactly those 40 cycles.
- Round-robin:
  - Stimulus: req=1111 held continuously, data bytes 8'h10, 8'h21, 8'h32, 8'h43.
  - Required: grants in order 0,1,2,3,0; each tx frame carries the matching byte; a 1-cycle tx=1 gap between frames.
- Pointer skip:
  - Stimulus: after a grant to 1, assert req=0011.
  - Required: next grant is requester 0 (pointer at 2, scan 2,3,0), src_id=0.
- Withdrawn and late requests:
  - Stimulus: pulse req[2] only during a busy frame, dropping it before IDLE.
  - Required: no grant to 2. A separate req[3] asserted mid-frame and held is granted in the IDLE cycle right after frame_done.
- Reset mid-frame:
  - Stimulus: assert Reset during DATA bit 4.
  - Required: tx=1 and busy=0 without waiting for a clock edge.
  - Required after release with req=0100: grant to 2; the frame restarts from the start bit, with no residual bits of the old frame.
